// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file slice.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   DEPTH                   : default number of registers (1 << ADDR_W_DEF)
//   addr_t / data_t         : default-width address and data vectors
//   depth_of()              : register count for a given address width
// Optional feature macro (used by importers): REGFILE_ZERO_REG_EN.
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits tracking pending writebacks.
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en, wr_addr  : a write retires the pending writeback (clears busy)
//   rsv_en, rsv_addr: a reserve marks a register busy (set wins over clear)
//   busy_vec        : registered busy bit of every register
//   busy_next       : busy value being loaded on this edge (for read ports)
// Macro REGFILE_ZERO_REG_EN: register 0 can never become busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int NREG  = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [NREG-1:0]   busy_next
);
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      // Clear first, then set: a new producer issued on the same edge as
      // the old one's writeback keeps the register busy.
      if (wr_en && (wr_addr == ADDR_W'(r)))   busy_d[r] = 1'b0;
      if (rsv_en && (rsv_addr == ADDR_W'(r))) busy_d[r] = 1'b1;
    end
`ifdef REGFILE_ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec  = busy_q;
  assign busy_next = busy_d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with NUM_RD synchronous read ports,
// write-first bypass and a per-register busy scoreboard.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all)
//   rd_en/rd_addr     : per-port read enable and address (packed by port)
//   rd_data/rd_busy   : registered read data and busy flag, held when !rd_en
//   wr_en/addr/data   : register write
//   rsv_en/rsv_addr   : reserve a register (mark busy)
//   busy_vec          : registered busy bit of every register
// Macro REGFILE_ZERO_REG_EN: register 0 reads as zero, ignores writes and
// reserves, and never bypasses.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  localparam int NREG  = depth_of(ADDR_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NREG-1:0]          busy_vec
);
  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [DATA_W-1:0] rd_data_d [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_q;
  logic [NUM_RD-1:0] rd_busy_d;
  logic [NREG-1:0]   busy_next;
  logic              wr_ok;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok = wr_en && (wr_addr != '0);
`else
  assign wr_ok = wr_en;
`endif

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_vec  (busy_vec),
    .busy_next (busy_next)
  );

  // mem_d is the post-write image; reading it gives write-first bypass
  // for free, and a suppressed write to r0 leaves it at its reset zero.
  always_comb begin
    for (int r = 0; r < NREG; r++) mem_d[r] = mem_q[r];
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= mem_d[r];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_d[p] = rd_data_q[p];
      rd_busy_d[p] = rd_busy_q[p];
      if (rd_en[p]) begin
        rd_data_d[p] = mem_d[rd_addr[p*ADDR_W +: ADDR_W]];
        rd_busy_d[p] = busy_next[rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) rd_data_q[p] <= rd_data_d[p];
      rd_busy_q <= rd_busy_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_pack
    assign rd_data[gi*DATA_W +: DATA_W] = rd_data_q[gi];
  end
  assign rd_busy = rd_busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int DW = 16, AW = 4, NR = 2, NREG = 16;
  localparam int DW2 = 32, AW2 = 5, NR2 = 3, NREG2 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    rd_en = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             rsv_en = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;
  logic [NREG-1:0]  busy_vec;

  logic [NR2-1:0]     d2_rd_en = '0;
  logic [NR2*AW2-1:0] d2_rd_addr = '0;
  logic [NR2*DW2-1:0] d2_rd_data;
  logic [NR2-1:0]     d2_rd_busy;
  logic               d2_wr_en = 1'b0;
  logic [AW2-1:0]     d2_wr_addr = '0;
  logic [DW2-1:0]     d2_wr_data = '0;
  logic               d2_rsv_en = 1'b0;
  logic [AW2-1:0]     d2_rsv_addr = '0;
  logic [NREG2-1:0]   d2_busy_vec;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  regfile_sb #(.DATA_W(DW2), .ADDR_W(AW2), .NUM_RD(NR2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rd_en(d2_rd_en), .rd_addr(d2_rd_addr),
    .rd_data(d2_rd_data), .rd_busy(d2_rd_busy), .wr_en(d2_wr_en),
    .wr_addr(d2_wr_addr), .wr_data(d2_wr_data), .rsv_en(d2_rsv_en),
    .rsv_addr(d2_rsv_addr), .busy_vec(d2_busy_vec)
  );

  // Reference model: architectural state as plain arrays.
  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;
  logic [DW-1:0]   m_rd [NR];
  logic [NR-1:0]   m_rbusy;
`ifdef REGFILE_ZERO_REG_EN
  bit zero_reg = 1'b1;
`else
  bit zero_reg = 1'b0;
`endif

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_mem[r] = '0;
    m_busy = '0;
    for (int p = 0; p < NR; p++) m_rd[p] = '0;
    m_rbusy = '0;
  endtask

  // One clock edge of architectural behaviour: write lands, busy updated
  // (reserve after retire so it wins), then enabled ports read the result.
  task automatic model_edge();
    logic [AW-1:0] a;
    if (!rst_n) return;
    if (wr_en && !(zero_reg && wr_addr == 0)) begin
      m_mem[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (rsv_en && !(zero_reg && rsv_addr == 0)) m_busy[rsv_addr] = 1'b1;
    for (int p = 0; p < NR; p++) begin
      if (rd_en[p]) begin
        a = rd_addr[p*AW +: AW];
        m_rd[p] = m_mem[a];
        m_rbusy[p] = m_busy[a];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic we, input int wa, input int wd,
                        input logic [NR-1:0] re, input int ra0, input int ra1,
                        input logic rv, input int rva);
    wr_en = we; wr_addr = AW'(wa); wr_data = DW'(wd);
    rd_en = re; rd_addr = {AW'(ra1), AW'(ra0)};
    rsv_en = rv; rsv_addr = AW'(rva);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_busy_vec"}, 64'(busy_vec), 64'(m_busy));
    for (int p = 0; p < NR; p++) begin
      check({tag, "_rd_data"}, 64'(rd_data[p*DW +: DW]), 64'(m_rd[p]));
      check({tag, "_rd_busy"}, 64'(rd_busy[p]), 64'(m_rbusy[p]));
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) tick();
    check("reset_rd_data", 64'(rd_data), 64'h0);
    check("reset_busy_vec", 64'(busy_vec), 64'h0);
    check("reset_rd_busy", 64'(rd_busy), 64'h0);
    rst_n = 1'b1;
    $display("step: reset released");

    // Reset mid-operation
    set_in(1, 3, 'h1234, 2'b00, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 2'b01, 3, 0, 1, 4); tick();
    check("pre_rst_rd", 64'(rd_data[DW-1:0]), 64'h1234);
    check("pre_rst_busy4", 64'(busy_vec[4]), 64'h1);
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0);
    #3 rst_n = 1'b0; model_reset();
    #1;
    check("async_rst_rd_data", 64'(rd_data), 64'h0);
    check("async_rst_busy_vec", 64'(busy_vec), 64'h0);
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 2'b11, 3, 3, 0, 0); tick();
    check("post_rst_r3", 64'(rd_data), 64'h0);
    $display("step: reset mid-operation");

    // Basic write/read on both ports
    set_in(1, 5, 'hBEEF, 2'b00, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 2'b11, 5, 5, 0, 0); tick();
    check("rd_r5_p0", 64'(rd_data[DW-1:0]), 64'hBEEF);
    check("rd_r5_p1", 64'(rd_data[2*DW-1:DW]), 64'hBEEF);
    $display("step: write/read r5");

    // Write-first bypass, then hold with rd_en=0
    set_in(1, 7, 'h0001, 2'b00, 0, 0, 0, 0); tick();
    set_in(1, 7, 'hA5A5, 2'b11, 7, 7, 0, 0); tick();
    check("bypass_p0", 64'(rd_data[DW-1:0]), 64'hA5A5);
    check("bypass_p1", 64'(rd_data[2*DW-1:DW]), 64'hA5A5);
    set_in(1, 7, 'h5555, 2'b00, 7, 7, 0, 0); tick();
    check("hold_p0", 64'(rd_data[DW-1:0]), 64'hA5A5);
    check("hold_p1", 64'(rd_data[2*DW-1:DW]), 64'hA5A5);
    $display("step: bypass and hold");

    // Scoreboard
    set_in(0, 0, 0, 2'b00, 0, 0, 1, 2); tick();
    check("rsv_busy2", 64'(busy_vec[2]), 64'h1);
    set_in(0, 0, 0, 2'b01, 2, 0, 0, 0); tick();
    check("rd_busy_r2", 64'(rd_busy[0]), 64'h1);
    set_in(1, 2, 'h0042, 2'b00, 0, 0, 0, 0); tick();
    check("wr_clears_busy2", 64'(busy_vec[2]), 64'h0);
    set_in(1, 2, 'h0042, 2'b00, 0, 0, 1, 2); tick();
    check("rsv_wr_busy2", 64'(busy_vec[2]), 64'h1);
    set_in(0, 0, 0, 2'b10, 0, 2, 0, 0); tick();
    check("rsv_wr_data2", 64'(rd_data[2*DW-1:DW]), 64'h0042);
    check("rsv_wr_rdbusy2", 64'(rd_busy[1]), 64'h1);
    set_in(0, 0, 0, 2'b00, 0, 0, 1, 2); tick();
    check("rsv_again_busy2", 64'(busy_vec[2]), 64'h1);
    $display("step: scoreboard");

    // Register 0 behaviour
    set_in(1, 0, 'hFFFF, 2'b01, 0, 0, 1, 0); tick();
`ifdef REGFILE_ZERO_REG_EN
    check("zero_rd", 64'(rd_data[DW-1:0]), 64'h0);
    check("zero_busy0", 64'(busy_vec[0]), 64'h0);
`else
    check("zero_rd", 64'(rd_data[DW-1:0]), 64'hFFFF);
    check("zero_busy0", 64'(busy_vec[0]), 64'h1);
`endif
    check_model("directed_end");
    $display("step: register 0");

    // Wider configuration instance
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0);
    d2_wr_en = 1'b1; d2_wr_addr = 5'd31; d2_wr_data = 32'hDEADBEEF; tick();
    d2_wr_en = 1'b0; d2_rd_en = 3'b111; d2_rd_addr = {5'd31, 5'd0, 5'd31}; tick();
    d2_rd_en = 3'b000;
    check("d2_p0", 64'(d2_rd_data[31:0]), 64'hDEADBEEF);
    check("d2_p1", 64'(d2_rd_data[63:32]), 64'h0);
    check("d2_p2", 64'(d2_rd_data[95:64]), 64'hDEADBEEF);
    $display("step: 32x32 three-port instance");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, NREG-1)),
             int'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)),
             1'($urandom_range(0, 3) == 0), int'($urandom_range(0, NREG-1)));
      tick();
      check_model("rand");
    end
    $display("step: random traffic, 400 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
